uart_tx_arbiter: RTL

Shares the single UART transmitter in `top` between `N_REQ` byte producers. Arbitrates pending requests, loads the winner's byte onto `tx_data`, and drives `transmit` high for one bit period. Holds the UART busy for a full frame plus guard time, then re-arbitrates. Sits between the requesting blocks and the `tx_data`/`transmit` inputs of `top`.

---
 rtl/uart_tx_arbiter_if.sv | 25 ++
 rtl/uart_tx_arbiter.sv | 128 ++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between byte producers, the UART arbiter and the UART.
// The slave side is the arbiter; the master side is the producers plus UART.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  localparam int IW = $clog2(N_REQ);

  logic [N_REQ-1:0]   req;
  logic [N_REQ*8-1:0] req_data;
  logic [N_REQ-1:0]   ack;
  logic [7:0]         tx_data;
  logic               transmit;
  logic               busy;
  logic [IW-1:0]      grant_id;

  modport master (
    output req, req_data,
    input  ack, tx_data, transmit, busy, grant_id
  );

  modport slave (
    input  req, req_data,
    output ack, tx_data, transmit, busy, grant_id
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between N_REQ byte producers.
// Define UART_ARB_FIXED_PRIO_EN for fixed (lowest index) priority.
module uart_tx_arbiter #(
  parameter int N_REQ          = 4,
  parameter int CLKS_PER_BIT   = 434,
  parameter int BITS_PER_FRAME = 11,
  parameter int GUARD_BITS     = 1
) (
  input logic              clk,
  input logic              rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int NB = BITS_PER_FRAME + GUARD_BITS;
  localparam int BW = $clog2(NB);
  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(NB - 1);

  typedef logic [7:0] data_t;
  typedef enum logic [1:0] {IDLE, SEND, HOLD} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cyc_q, cyc_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  data_t            tx_data_q, tx_data_d;
  logic [IW-1:0]    grant_q, grant_d;
  logic [IW-1:0]    win;

`ifdef UART_ARB_FIXED_PRIO_EN
  always_comb begin
    win = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (bus.req[IW'(i)]) win = IW'(i);
  end
`else
  logic [IW-1:0] last_q, last_d;
  int            idx;
  logic          found;

  // Scan starts one past the last winner and wraps.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = int'(last_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && bus.req[IW'(idx)]) begin
        win   = IW'(idx);
        found = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    bit_d     = bit_q;
    ack_d     = '0;
    tx_data_d = tx_data_q;
    grant_d   = grant_q;
`ifndef UART_ARB_FIXED_PRIO_EN
    last_d    = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|bus.req) begin
          ack_d[win] = 1'b1;
          tx_data_d  = bus.req_data[{win, 3'b000} +: 8];
          grant_d    = win;
`ifndef UART_ARB_FIXED_PRIO_EN
          last_d     = win;
`endif
          cyc_d      = '0;
          bit_d      = '0;
          state_d    = SEND;
        end
      end
      SEND, HOLD: begin
        cyc_d = cyc_q + CW'(1);
        if (cyc_q == CYC_LAST) begin
          cyc_d = '0;
          bit_d = bit_q + BW'(1);
          if (state_q == SEND) state_d = HOLD;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cyc_q     <= '0;
      bit_q     <= '0;
      ack_q     <= '0;
      tx_data_q <= '0;
      grant_q   <= '0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      bit_q     <= bit_d;
      ack_q     <= ack_d;
      tx_data_q <= tx_data_d;
      grant_q   <= grant_d;
    end
  end

`ifndef UART_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk) begin
    if (!rst) last_q <= IW'(N_REQ - 1);
    else      last_q <= last_d;
  end
`endif

  assign bus.ack      = ack_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.transmit = (state_q == SEND);
  assign bus.busy     = (state_q != IDLE);
  assign bus.grant_id = grant_q;
endmodule
